// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the lockable round-robin arbiter.
// The helpers use 32-bit operands, so N is limited to 32 requesters.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  localparam int unsigned OH_MAX = 32;

  // OR-reduction encode; exact for one-hot input and 0 for an all-zero input.
  function automatic logic [31:0] onehot2bin(input logic [OH_MAX-1:0] oh);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < OH_MAX; i++) begin
      idx = idx | (oh[i] ? 32'(i) : 32'd0);
    end
    return idx;
  endfunction

  function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
    return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arb_lock_pick.sv
// Combinational round-robin pick: rotate req by ptr, take the lowest set bit,
// then map the offset back to an absolute index with an explicit mod-N wrap.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] win_id
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IDW:0]   off_s;
  logic [IDW:0]   sum_s;
  logic           found_s;

  // Rotate-and-priority-encode; the doubled vector makes any N work.
  always_comb begin
    dbl_s   = {req, req} >> ptr;
    rot_s   = dbl_s[N-1:0];
    off_s   = {(IDW+1){1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && rot_s[i]) begin
        off_s   = (IDW+1)'(i);
        found_s = 1'b1;
      end else begin
        off_s   = off_s;
      end
    end
    any   = |req;
    sum_s = {1'b0, ptr} + off_s;
    if (sum_s >= (IDW+1)'(N)) begin
      win_id = IDW'(sum_s - (IDW+1)'(N));
    end else begin
      win_id = IDW'(sum_s);
    end
  end

endmodule

// File: rtl/rr_arb_lock.sv
// N-way round-robin arbiter with registered one-hot grant, burst locking
// and a bounded hold counter that forces preemption of a locking owner.
module rr_arb_lock
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N),
  parameter int HCW      = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           preempt
);

  arb_state_t     state_r, state_s;
  logic [IDW-1:0] ptr_r, ptr_s;
  logic [HCW-1:0] hold_r, hold_s;
  logic [N-1:0]   gnt_s;
  logic [IDW-1:0] gnt_id_s;
  logic           vld_s;
  logic           preempt_s;
  logic           any_s;
  logic [IDW-1:0] win_s;
  logic           keep_s;
  logic           at_max_s;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .any    (any_s),
    .win_id (win_s)
  );

  // Owner lock request and saturation of the hold counter.
  always_comb begin
    keep_s   = (state_r != IDLE) && req[gnt_id] && lock[gnt_id];
    at_max_s = (hold_r == HCW'(MAX_HOLD));
  end

  // Next-state, next-grant and preempt decision.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    hold_s    = hold_r;
    gnt_s     = gnt;
    preempt_s = 1'b0;
    case (state_r)
      IDLE, GNT, HOLD: begin
        if (keep_s && !at_max_s) begin
          state_s = HOLD;
          hold_s  = hold_r + HCW'(1);
        end else begin
          // A lock reaching this branch means the hold budget ran out.
          preempt_s = keep_s;
          if (any_s) begin
            gnt_s   = {{(N-1){1'b0}}, 1'b1} << win_s;
            ptr_s   = IDW'(wrap_inc(32'(win_s), 32'(N)));
            hold_s  = HCW'(1);
            state_s = GNT;
          end else begin
            gnt_s   = {N{1'b0}};
            hold_s  = {HCW{1'b0}};
            state_s = IDLE;
          end
        end
      end
      default: begin
        gnt_s   = {N{1'b0}};
        hold_s  = {HCW{1'b0}};
        state_s = IDLE;
      end
    endcase
    gnt_id_s = IDW'(onehot2bin(32'(gnt_s)));
    vld_s    = |gnt_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= {IDW{1'b0}};
      hold_r  <= {HCW{1'b0}};
      gnt     <= {N{1'b0}};
      gnt_id  <= {IDW{1'b0}};
      gnt_vld <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
      gnt     <= gnt_s;
      gnt_id  <= gnt_id_s;
      gnt_vld <= vld_s;
      preempt <= preempt_s;
    end
  end

endmodule

// File: tb/tb_rr_arb_lock.sv
// Scoreboard bench for rr_arb_lock: three instances with different N/MAX_HOLD,
// directed vectors push expected outputs, a monitor compares on the falling edge.
module tb_rr_arb_lock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] req_a = 4'd0, lock_a = 4'd0, gnt_a;
  logic [1:0] id_a;
  logic       vld_a, pre_a;
  logic [4:0] req_b = 5'd0, lock_b = 5'd0, gnt_b;
  logic [2:0] id_b;
  logic       vld_b, pre_b;
  logic [3:0] req_c = 4'd0, lock_c = 4'd0, gnt_c;
  logic [1:0] id_c;
  logic       vld_c, pre_c;

  rr_arb_lock #(.N(4), .MAX_HOLD(3)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .lock(lock_a),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .preempt(pre_a));
  rr_arb_lock #(.N(5), .MAX_HOLD(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .lock(lock_b),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .preempt(pre_b));
  rr_arb_lock #(.N(4), .MAX_HOLD(2)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .lock(lock_c),
    .gnt(gnt_c), .gnt_id(id_c), .gnt_vld(vld_c), .preempt(pre_c));

  typedef struct {
    int         sel;
    logic [4:0] gnt;
    logic [2:0] id;
    logic       pre;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are stable on the falling edge
  initial begin
    exp_t e;
    logic [4:0] g;
    logic [2:0] id;
    logic       v, p;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       begin g = {1'b0, gnt_a}; id = {1'b0, id_a}; v = vld_a; p = pre_a; end
          1:       begin g = gnt_b;         id = id_b;         v = vld_b; p = pre_b; end
          default: begin g = {1'b0, gnt_c}; id = {1'b0, id_c}; v = vld_c; p = pre_c; end
        endcase
        chk({e.name, " gnt"}, 32'(g), 32'(e.gnt));
        chk({e.name, " gnt_id"}, 32'(id), 32'(e.id));
        chk({e.name, " gnt_vld"}, 32'(v), 32'(|e.gnt));
        chk({e.name, " preempt"}, 32'(p), 32'(e.pre));
      end
    end
  end

  task automatic step(input int sel, input logic [4:0] r, input logic [4:0] l,
                      input logic [4:0] eg, input logic [2:0] eid, input logic ep,
                      input string nm);
    exp_t e;
    @(negedge clk);
    case (sel)
      0:       begin req_a = r[3:0]; lock_a = l[3:0]; end
      1:       begin req_b = r;      lock_b = l;      end
      default: begin req_c = r[3:0]; lock_c = l[3:0]; end
    endcase
    @(posedge clk);
    #1;
    e.sel = sel; e.gnt = eg; e.id = eid; e.pre = ep; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    #12;
    chk("reset gnt_a", 32'(gnt_a), 32'd0);
    chk("reset vld_a", 32'(vld_a), 32'd0);
    chk("reset pre_a", 32'(pre_a), 32'd0);
    chk("reset gnt_b", 32'(gnt_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain rotation with all requesting
    step(0, 5'b01111, 5'b00000, 5'b00001, 3'd0, 1'b0, "rr0");
    step(0, 5'b01111, 5'b00000, 5'b00010, 3'd1, 1'b0, "rr1");
    step(0, 5'b01111, 5'b00000, 5'b00100, 3'd2, 1'b0, "rr2");
    step(0, 5'b01111, 5'b00000, 5'b01000, 3'd3, 1'b0, "rr3");
    step(0, 5'b01111, 5'b00000, 5'b00001, 3'd0, 1'b0, "rr4");
    step(0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, "rr_idle");

    // Lock timeout with MAX_HOLD=3, ptr=1
    step(0, 5'b00110, 5'b00010, 5'b00010, 3'd1, 1'b0, "lk1");
    step(0, 5'b00110, 5'b00010, 5'b00010, 3'd1, 1'b0, "lk2");
    step(0, 5'b00110, 5'b00010, 5'b00010, 3'd1, 1'b0, "lk3");
    step(0, 5'b00110, 5'b00010, 5'b00100, 3'd2, 1'b1, "lk_timeout");
    step(0, 5'b00110, 5'b00010, 5'b00010, 3'd1, 1'b0, "lk_wrap");
    step(0, 5'b00110, 5'b00010, 5'b00010, 3'd1, 1'b0, "lk_hold");

    // Owner drops req mid-hold, then everything idles, ptr stays at 0
    step(0, 5'b01000, 5'b00010, 5'b01000, 3'd3, 1'b0, "drop");
    step(0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, "all_idle");
    step(0, 5'b01111, 5'b00000, 5'b00001, 3'd0, 1'b0, "ptr_kept");

    // N=5 wrap 4 -> 0
    step(1, 5'b10001, 5'b00000, 5'b00001, 3'd0, 1'b0, "n5_0");
    step(1, 5'b10001, 5'b00000, 5'b10000, 3'd4, 1'b0, "n5_1");
    step(1, 5'b10001, 5'b00000, 5'b00001, 3'd0, 1'b0, "n5_2");
    step(1, 5'b10001, 5'b00000, 5'b10000, 3'd4, 1'b0, "n5_3");

    // Sole locking requester, MAX_HOLD=2
    step(2, 5'b00100, 5'b00100, 5'b00100, 3'd2, 1'b0, "solo1");
    step(2, 5'b00100, 5'b00100, 5'b00100, 3'd2, 1'b0, "solo2");
    step(2, 5'b00100, 5'b00100, 5'b00100, 3'd2, 1'b1, "solo3");
    step(2, 5'b00100, 5'b00100, 5'b00100, 3'd2, 1'b0, "solo4");
    step(2, 5'b00100, 5'b00100, 5'b00100, 3'd2, 1'b1, "solo5");

    // Reach HOLD on dut_a, then reset between edges
    step(0, 5'b00010, 5'b00010, 5'b00010, 3'd1, 1'b0, "pre_rst1");
    step(0, 5'b00010, 5'b00010, 5'b00010, 3'd1, 1'b0, "pre_rst2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async gnt", 32'(gnt_a), 32'd0);
    chk("async vld", 32'(vld_a), 32'd0);
    chk("async pre", 32'(pre_a), 32'd0);
    req_a = 4'd0; lock_a = 4'd0; req_c = 4'd0; lock_c = 4'd0; req_b = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 5'b01100, 5'b00000, 5'b00100, 3'd2, 1'b0, "post_rst");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
